// File: rtl/memory_bus_controller.sv
// Single-master bus controller: decodes a processor request onto one of
// SLAVES channels, waits for that slave's ack or a timeout, then responds.
module memory_bus_controller #(
    parameter int                          DATA_SIZE = 64,
    parameter int                          ADDR_SIZE = 64,
    parameter int                          SLAVES    = 4,
    parameter logic [SLAVES*ADDR_SIZE-1:0] BASE      = '0,
    parameter logic [SLAVES*ADDR_SIZE-1:0] MASK      = '0,
    parameter int                          TIMEOUT   = 255
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        mem_rd_en,
    input  logic                        mem_wr_en,
    input  logic [DATA_SIZE/8-1:0]      mem_byte_en,
    input  logic [ADDR_SIZE-1:0]        mem_addr,
    input  logic [DATA_SIZE-1:0]        wr_data,
    output logic [DATA_SIZE-1:0]        rd_data,
    output logic                        mem_busy,
    output logic                        mem_ack,
    output logic                        mem_err,
    output logic [SLAVES-1:0]           slv_en,
    output logic                        slv_rd_en,
    output logic                        slv_wr_en,
    output logic [DATA_SIZE/8-1:0]      slv_byte_en,
    output logic [ADDR_SIZE-1:0]        slv_addr,
    output logic [DATA_SIZE-1:0]        slv_wr_data,
    input  logic [SLAVES*DATA_SIZE-1:0] slv_rd_data,
    input  logic [SLAVES-1:0]           slv_ack
);

    localparam int BE_W = DATA_SIZE / 8;
    localparam int SW   = (SLAVES > 1) ? $clog2(SLAVES) : 1;
    localparam int CW   = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RESP,
        ERROR
    } state_e;

    state_e               state_q, state_d;
    logic [ADDR_SIZE-1:0] addr_q, addr_d;
    logic [DATA_SIZE-1:0] wdata_q, wdata_d;
    logic [BE_W-1:0]      be_q, be_d;
    logic                 wr_q, wr_d;
    logic [SW-1:0]        sel_q, sel_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [DATA_SIZE-1:0] rdata_q, rdata_d;

    logic                 hit;
    logic [SW-1:0]        hit_idx;
    logic [ADDR_SIZE-1:0] sel_mask;
    logic [DATA_SIZE-1:0] sel_rdata;
    logic [DATA_SIZE-1:0] be_mask;
    logic                 sel_ack;
    logic                 expired;
    logic                 in_access;

    // Descending scan so the lowest matching index is the last one written.
    always_comb begin
        hit     = 1'b0;
        hit_idx = '0;
        for (int i = SLAVES - 1; i >= 0; i--) begin
            if ((mem_addr & MASK[i*ADDR_SIZE +: ADDR_SIZE])
                == BASE[i*ADDR_SIZE +: ADDR_SIZE]) begin
                hit     = 1'b1;
                hit_idx = SW'(i);
            end
        end
    end

    always_comb begin
        sel_mask  = '0;
        sel_rdata = '0;
        sel_ack   = 1'b0;
        for (int i = 0; i < SLAVES; i++) begin
            if (sel_q == SW'(i)) begin
                sel_mask  = MASK[i*ADDR_SIZE +: ADDR_SIZE];
                sel_rdata = slv_rd_data[i*DATA_SIZE +: DATA_SIZE];
                sel_ack   = slv_ack[i];
            end
        end
    end

    always_comb begin
        be_mask = '0;
        for (int b = 0; b < BE_W; b++) begin
            be_mask[b*8 +: 8] = {8{be_q[b]}};
        end
    end

    assign expired = (TIMEOUT != 0) && (cnt_q == CW'(TIMEOUT - 1));

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        be_d    = be_q;
        wr_d    = wr_q;
        sel_d   = sel_q;
        cnt_d   = cnt_q;
        rdata_d = rdata_q;
        unique case (state_q)
            IDLE: begin
                if (mem_rd_en && mem_wr_en) begin
                    state_d = ERROR;
                    rdata_d = '0;
                end else if (mem_rd_en || mem_wr_en) begin
                    addr_d  = mem_addr;
                    wdata_d = wr_data;
                    be_d    = mem_byte_en;
                    wr_d    = mem_wr_en;
                    sel_d   = hit_idx;
                    cnt_d   = '0;
                    if (hit) begin
                        state_d = ACCESS;
                    end else begin
                        state_d = ERROR;
                        rdata_d = '0;
                    end
                end
            end
            ACCESS: begin
                // A late ack beats an expiring count in the same cycle.
                if (sel_ack) begin
                    state_d = RESP;
                    if (!wr_q) begin
                        rdata_d = sel_rdata & be_mask;
                    end
                end else if (expired) begin
                    state_d = ERROR;
                    rdata_d = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            RESP:    state_d = IDLE;
            ERROR:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            be_q    <= '0;
            wr_q    <= 1'b0;
            sel_q   <= '0;
            cnt_q   <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            be_q    <= be_d;
            wr_q    <= wr_d;
            sel_q   <= sel_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
        end
    end

    // Slave-side outputs are gated by state so reset drops them at once.
    assign in_access   = (state_q == ACCESS);
    assign mem_busy    = in_access;
    assign mem_ack     = (state_q == RESP) || (state_q == ERROR);
    assign mem_err     = (state_q == ERROR);
    assign slv_en      = in_access ? (SLAVES'(1) << sel_q) : '0;
    assign slv_rd_en   = in_access && !wr_q;
    assign slv_wr_en   = in_access && wr_q;
    assign slv_byte_en = in_access ? be_q : '0;
    assign slv_addr    = in_access ? (addr_q & ~sel_mask) : '0;
    assign slv_wr_data = in_access ? wdata_q : '0;
    assign rd_data     = rdata_q;

endmodule

// File: tb/tb_memory_bus_controller.sv
// Directed plus randomized bench for memory_bus_controller with a
// range-based reference model of the two-slave memory map.
module tb_memory_bus_controller;

    localparam int DW = 64;
    localparam int AW = 64;
    localparam int NS = 2;
    localparam int TO = 8;
    localparam logic [NS*AW-1:0] P_BASE =
        {64'h0000_0000_0400_0000, 64'h0000_0000_0000_0000};
    localparam logic [NS*AW-1:0] P_MASK =
        {64'hFFFF_FFFF_FC00_0000, 64'hFFFF_FFFF_FF00_0000};

    logic             clock;
    logic             reset;
    logic             mem_rd_en;
    logic             mem_wr_en;
    logic [DW/8-1:0]  mem_byte_en;
    logic [AW-1:0]    mem_addr;
    logic [DW-1:0]    wr_data;
    logic [DW-1:0]    rd_data;
    logic             mem_busy;
    logic             mem_ack;
    logic             mem_err;
    logic [NS-1:0]    slv_en;
    logic             slv_rd_en;
    logic             slv_wr_en;
    logic [DW/8-1:0]  slv_byte_en;
    logic [AW-1:0]    slv_addr;
    logic [DW-1:0]    slv_wr_data;
    logic [NS*DW-1:0] slv_rd_data;
    logic [NS-1:0]    slv_ack;

    int passes = 0;
    int fails  = 0;
    int total  = 0;
    logic [63:0] exp_rd;

    memory_bus_controller #(
        .DATA_SIZE(DW),
        .ADDR_SIZE(AW),
        .SLAVES(NS),
        .BASE(P_BASE),
        .MASK(P_MASK),
        .TIMEOUT(TO)
    ) dut (
        .clock(clock),
        .reset(reset),
        .mem_rd_en(mem_rd_en),
        .mem_wr_en(mem_wr_en),
        .mem_byte_en(mem_byte_en),
        .mem_addr(mem_addr),
        .wr_data(wr_data),
        .rd_data(rd_data),
        .mem_busy(mem_busy),
        .mem_ack(mem_ack),
        .mem_err(mem_err),
        .slv_en(slv_en),
        .slv_rd_en(slv_rd_en),
        .slv_wr_en(slv_wr_en),
        .slv_byte_en(slv_byte_en),
        .slv_addr(slv_addr),
        .slv_wr_data(slv_wr_data),
        .slv_rd_data(slv_rd_data),
        .slv_ack(slv_ack)
    );

    always #5 clock = ~clock;

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] expv);
        total++;
        assert (obs === expv) passes++;
        else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // Memory map: slave0 owns [0, 16M), slave1 owns [64M, 128M).
    function automatic int decode(input logic [63:0] a,
                                  output logic [63:0] off);
        if (a < 64'h0100_0000) begin
            off = a;
            return 0;
        end
        if (a >= 64'h0400_0000 && a < 64'h0800_0000) begin
            off = a - 64'h0400_0000;
            return 1;
        end
        off = 64'h0;
        return -1;
    endfunction

    function automatic logic [63:0] keep(input logic [63:0] d,
                                         input logic [7:0] be);
        logic [63:0] r;
        r = 64'h0;
        for (int b = 0; b < 8; b++) begin
            if (be[b]) r[b*8 +: 8] = d[b*8 +: 8];
        end
        return r;
    endfunction

    task automatic txn(input string nm, input bit rd, input bit wr,
                       input logic [7:0] be, input logic [63:0] addr,
                       input logic [63:0] data, input logic [63:0] s0,
                       input logic [63:0] s1, input int delay);
        int          idx;
        logic [63:0] off;
        logic [1:0]  en_exp;
        bit          done;
        bit          ak;
        bit          other;
        chk({nm, ".idle_ack"}, 64'(mem_ack), 64'd0);
        chk({nm, ".idle_busy"}, 64'(mem_busy), 64'd0);
        idx = decode(addr, off);
        en_exp = (idx == 0) ? 2'b01 : 2'b10;
        mem_rd_en   = rd;
        mem_wr_en   = wr;
        mem_byte_en = be;
        mem_addr    = addr;
        wr_data     = data;
        slv_rd_data = {s1, s0};
        @(posedge clock); #1;
        mem_rd_en   = 1'b0;
        mem_wr_en   = 1'b0;
        mem_addr    = {$urandom, $urandom};
        wr_data     = {$urandom, $urandom};
        mem_byte_en = 8'($urandom);
        if ((rd && wr) || idx < 0) begin
            exp_rd = 64'h0;
            chk({nm, ".err_ack"}, 64'(mem_ack), 64'd1);
            chk({nm, ".err_err"}, 64'(mem_err), 64'd1);
            chk({nm, ".err_rd"}, rd_data, 64'h0);
            chk({nm, ".err_en"}, 64'(slv_en), 64'd0);
            chk({nm, ".err_busy"}, 64'(mem_busy), 64'd0);
        end else begin
            done = 1'b0;
            for (int k = 0; k < TO; k++) begin
                chk({nm, ".busy"}, 64'(mem_busy), 64'd1);
                chk({nm, ".en"}, 64'(slv_en), 64'(en_exp));
                chk({nm, ".rden"}, 64'(slv_rd_en), 64'(!wr));
                chk({nm, ".wren"}, 64'(slv_wr_en), 64'(wr));
                chk({nm, ".be"}, 64'(slv_byte_en), 64'(be));
                chk({nm, ".addr"}, slv_addr, off);
                chk({nm, ".hold_rd"}, rd_data, exp_rd);
                chk({nm, ".no_ack"}, 64'(mem_ack), 64'd0);
                if (wr) chk({nm, ".wdata"}, slv_wr_data, data);
                ak    = (k == delay);
                other = 1'($urandom);
                slv_ack   = (idx == 0) ? {other, ak} : {ak, other};
                mem_rd_en = 1'($urandom);
                mem_wr_en = 1'($urandom);
                @(posedge clock); #1;
                slv_ack = 2'b00;
                if (k == delay) begin
                    done = 1'b1;
                    break;
                end
            end
            mem_rd_en = 1'b0;
            mem_wr_en = 1'b0;
            if (!done) exp_rd = 64'h0;
            else if (!wr) exp_rd = keep((idx == 0) ? s0 : s1, be);
            chk({nm, ".rsp_ack"}, 64'(mem_ack), 64'd1);
            chk({nm, ".rsp_err"}, 64'(mem_err), 64'(!done));
            chk({nm, ".rsp_rd"}, rd_data, exp_rd);
            chk({nm, ".rsp_busy"}, 64'(mem_busy), 64'd0);
            chk({nm, ".rsp_en"}, 64'(slv_en), 64'd0);
            chk({nm, ".rsp_strb"}, 64'({slv_rd_en, slv_wr_en}), 64'd0);
        end
        @(posedge clock); #1;
    endtask

    initial begin
        int          kind;
        int          op;
        logic [63:0] a;
        clock       = 1'b0;
        reset       = 1'b0;
        mem_rd_en   = 1'b0;
        mem_wr_en   = 1'b0;
        mem_byte_en = '0;
        mem_addr    = '0;
        wr_data     = '0;
        slv_rd_data = '0;
        slv_ack     = '0;
        exp_rd      = 64'h0;
        #2 reset = 1'b1;
        #1;
        chk("rst.rd", rd_data, 64'h0);
        chk("rst.en", 64'(slv_en), 64'd0);
        chk("rst.flags", 64'({mem_busy, mem_ack, mem_err}), 64'd0);
        chk("rst.strb", 64'({slv_rd_en, slv_wr_en}), 64'd0);
        chk("rst.addr", slv_addr, 64'h0);
        chk("rst.wdata", slv_wr_data, 64'h0);
        chk("rst.be", 64'(slv_byte_en), 64'd0);
        @(posedge clock);
        @(posedge clock); #1;
        reset = 1'b0;
        @(posedge clock); #1;

        txn("r020", 1, 0, 8'h0F, 64'h10, 64'h0,
            64'h1122_3344_5566_7788, 64'hFFFF_FFFF_FFFF_FFFF, 0);
        chk("r020.const", rd_data, 64'h0000_0000_5566_7788);
        txn("w021", 0, 1, 8'hFF, 64'h0400_0100, 64'hDEAD_BEEF,
            64'h1, 64'h2, 2);
        chk("w021.keep_rd", rd_data, 64'h0000_0000_5566_7788);
        txn("u022", 1, 0, 8'hFF, 64'h0800_0000, 64'h0,
            64'h3, 64'h4, 0);
        txn("t023", 1, 0, 8'hFF, 64'h40, 64'h0, 64'h5, 64'h6, 99);
        txn("b024", 1, 1, 8'hFF, 64'h10, 64'h0, 64'h7, 64'h8, 0);
        txn("late", 1, 0, 8'hA5, 64'h00FF_FFF8, 64'h0,
            64'h0102_0304_0506_0708, 64'h9, 7);
        txn("s1lo", 1, 0, 8'hF0, 64'h0400_0000, 64'h0,
            64'hA, 64'hCAFE_F00D_1234_5678, 1);
        txn("s1hi", 0, 1, 8'h3C, 64'h07FF_FFF8, 64'h55AA_55AA_55AA_55AA,
            64'hB, 64'hC, 0);
        txn("gap", 1, 0, 8'hFF, 64'h0100_0000, 64'h0, 64'hD, 64'hE, 0);

        txn("pre", 1, 0, 8'hFF, 64'h80, 64'h0,
            64'hA5A5_5A5A_1234_8765, 64'h0, 0);
        mem_rd_en   = 1'b1;
        mem_addr    = 64'h20;
        mem_byte_en = 8'hFF;
        @(posedge clock); #1;
        mem_rd_en = 1'b0;
        chk("rst_mid.busy1", 64'(mem_busy), 64'd1);
        @(posedge clock); #1;
        chk("rst_mid.busy2", 64'(mem_busy), 64'd1);
        #1 reset = 1'b1;
        #1;
        chk("rst_mid.en", 64'(slv_en), 64'd0);
        chk("rst_mid.busy", 64'(mem_busy), 64'd0);
        chk("rst_mid.rden", 64'(slv_rd_en), 64'd0);
        chk("rst_mid.rd", rd_data, 64'h0);
        chk("rst_mid.addr", slv_addr, 64'h0);
        exp_rd = 64'h0;
        @(posedge clock); #1;
        chk("rst_mid.ack1", 64'(mem_ack), 64'd0);
        @(posedge clock); #1;
        reset = 1'b0;
        chk("rst_mid.ack2", 64'(mem_ack), 64'd0);
        @(posedge clock); #1;
        chk("rst_mid.ack3", 64'(mem_ack), 64'd0);
        txn("post", 0, 1, 8'h0F, 64'h0400_0010, 64'h1234,
            64'h0, 64'h0, 0);

        for (int i = 0; i < 40; i++) begin
            kind = int'($urandom_range(0, 3));
            op   = int'($urandom_range(0, 4));
            if (kind == 0) a = 64'($urandom_range(0, 32'h00FF_FFFF));
            else if (kind == 1)
                a = 64'h0400_0000 + 64'($urandom_range(0, 32'h03FF_FFFF));
            else if (kind == 2)
                a = 64'h0100_0000 + 64'($urandom_range(0, 32'h02FF_FFFF));
            else a = {$urandom, $urandom} | 64'h8000_0000_0000_0000;
            txn($sformatf("rnd%0d", i), op != 2 && op != 3,
                op >= 2, 8'($urandom), a, {$urandom, $urandom},
                {$urandom, $urandom}, {$urandom, $urandom},
                int'($urandom_range(0, 9)));
        end

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule
